agc_ram_arbiter: RTL

Shares the single agc_ram instance between the AGC Core and the serial debug/loader port, so that a host can peek and poke erasable memory while the CPU runs. Core traffic has priority. A starvation counter forces the debug requester in for a bounded burst, and the Core is stalled for the duration. The block sits between Core/debug and agc_ram in ChipInterface, and its stall output is ORed into the Core's stall.

---
 rtl/agc_ram_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/agc_ram_arbiter.sv
// Arbitrates the single agc_ram between the AGC Core and the debug/loader port.
// Core has priority; a starvation counter forces bounded debug bursts while the Core stalls.
module agc_ram_arbiter #(
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned DATA_W    = 15,
    parameter int unsigned MAX_WAIT  = 8,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic [ADDR_W-1:0] ram_rdaddress,
    output logic              ram_rd_addrstall,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int unsigned BURST_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    typedef enum logic {
        ST_CORE,
        ST_DBG
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CORE,
        OWN_DBG
    } owner_t;

    state_t              state;
    owner_t              owner;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [BURST_W-1:0]  burst_cnt;
    logic [ADDR_W-1:0]   rd_addr_q;

    logic core_rd_gnt;
    logic core_wr_gnt;
    logic dbg_rd_gnt;
    logic dbg_wr_gnt;

    // Grant decode; nothing is granted while reset is held.
    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (reset_n) begin
            case (state)
                ST_CORE: begin
                    if (core_req) begin
                        core_gnt = 1'b1;
                    end else if (dbg_req) begin
                        dbg_gnt = 1'b1;
                    end
                end
                ST_DBG: begin
                    dbg_gnt = dbg_req;
                end
            endcase
        end
    end

    assign core_stall  = reset_n & core_req & ~core_gnt;
    assign core_rd_gnt = core_gnt & ~core_we;
    assign core_wr_gnt = core_gnt &  core_we;
    assign dbg_rd_gnt  = dbg_gnt  & ~dbg_we;
    assign dbg_wr_gnt  = dbg_gnt  &  dbg_we;

    // RAM port muxing; the read address holds its last value when no read is granted.
    always_comb begin
        ram_wren         = core_wr_gnt | dbg_wr_gnt;
        ram_wraddress    = '0;
        ram_data         = '0;
        ram_rd_addrstall = ~(core_rd_gnt | dbg_rd_gnt);
        ram_rdaddress    = rd_addr_q;
        if (core_wr_gnt) begin
            ram_wraddress = core_addr;
            ram_data      = core_wdata;
        end else if (dbg_wr_gnt) begin
            ram_wraddress = dbg_addr;
            ram_data      = dbg_wdata;
        end
        if (core_rd_gnt) begin
            ram_rdaddress = core_addr;
        end else if (dbg_rd_gnt) begin
            ram_rdaddress = dbg_addr;
        end
    end

    assign core_rvalid = (owner == OWN_CORE);
    assign dbg_rvalid  = (owner == OWN_DBG);
    assign core_rdata  = ram_q;
    assign dbg_rdata   = ram_q;

    // Arbitration state, starvation/burst counters and read-return owner tag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_CORE;
            wait_cnt  <= '0;
            burst_cnt <= '0;
            owner     <= OWN_NONE;
            rd_addr_q <= '0;
        end else begin
            rd_addr_q <= ram_rdaddress;
            if (core_rd_gnt) begin
                owner <= OWN_CORE;
            end else if (dbg_rd_gnt) begin
                owner <= OWN_DBG;
            end else begin
                owner <= OWN_NONE;
            end

            case (state)
                ST_CORE: begin
                    burst_cnt <= '0;
                    if (dbg_req && (wait_cnt == WAIT_W'(MAX_WAIT))) begin
                        state    <= ST_DBG;
                        wait_cnt <= '0;
                    end else if (!dbg_req || dbg_gnt) begin
                        wait_cnt <= '0;
                    end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_DBG: begin
                    wait_cnt <= '0;
                    if (!dbg_req || (burst_cnt == BURST_W'(BURST_MAX - 1))) begin
                        state     <= ST_CORE;
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_cnt + BURST_W'(1);
                    end
                end
            endcase
        end
    end

endmodule
